// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a scanned, multiplexed 7-segment bus: samples cat/seg,
// debounces each digit position and recovers committed BCD digits plus a 0..99 value.
module seg_scan_decoder #(
    parameter int NDIG   = 8,
    parameter int STABLE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          cat_in,
    input  logic [6:0]          seg_in,
    output logic [4*NDIG-1:0]   digit_bcd,
    output logic [NDIG-1:0]     digit_valid,
    output logic [6:0]          value,
    output logic                update,
    output logic                err_cat,
    output logic                err_seg,
    output logic [7:0]          err_count
);

    localparam int             CW      = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
    localparam logic [CW-1:0]  CNT_TOP = CW'(STABLE);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    // Returns {legal, numeral, bcd}; the all-dark pattern is legal but not a numeral.
    function automatic logic [5:0] seg_decode(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            7'b1111110: r = {1'b1, 1'b1, 4'd0};
            7'b0110000: r = {1'b1, 1'b1, 4'd1};
            7'b1101101: r = {1'b1, 1'b1, 4'd2};
            7'b1111001: r = {1'b1, 1'b1, 4'd3};
            7'b0110011: r = {1'b1, 1'b1, 4'd4};
            7'b1011011: r = {1'b1, 1'b1, 4'd5};
            7'b1011111: r = {1'b1, 1'b1, 4'd6};
            7'b1110000: r = {1'b1, 1'b1, 4'd7};
            7'b1111111: r = {1'b1, 1'b1, 4'd8};
            7'b1111011: r = {1'b1, 1'b1, 4'd9};
            7'b0000000: r = {1'b1, 1'b0, 4'd0};
            default:    r = 6'b000000;
        endcase
        return r;
    endfunction

    // Returns {hit, index}: hit only for a single low bit at a captured position.
    function automatic logic [3:0] select_index(input logic [7:0] cat);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < NDIG; i++) begin
            r = (cat == ~(8'b00000001 << i)) ? {1'b1, 3'(i)} : r;
        end
        return r;
    endfunction

    logic [7:0]     cat_s;
    logic [6:0]     seg_s;

    logic [3:0]     sel_info_sig;
    logic [5:0]     seg_info_sig;
    logic           idle_sig;
    logic           cat_ok_sig;
    logic           seg_ok_sig;
    logic [2:0]     smp_idx_sig;
    logic           smp_valid_sig;
    logic [3:0]     smp_bcd_sig;
    logic           accept_sig;
    logic           err_cat_sig;
    logic           err_seg_sig;

    logic           cand_valid_r   [NDIG];
    logic [3:0]     cand_bcd_r     [NDIG];
    logic [CW-1:0]  cnt_r          [NDIG];
    logic           cand_valid_nxt [NDIG];
    logic [3:0]     cand_bcd_nxt   [NDIG];
    logic [CW-1:0]  cnt_nxt        [NDIG];
    logic [NDIG-1:0] commit_sig;
    logic [6:0]     value_sig;

    // Input sample stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cat_s <= 8'hFF;
            seg_s <= 7'b0000000;
        end else begin
            cat_s <= cat_in;
            seg_s <= seg_in;
        end
    end

    // Classify the sampled select and segment pattern; seg is ignored for bad selects.
    always_comb begin
        sel_info_sig  = select_index(cat_s);
        seg_info_sig  = seg_decode(seg_s);
        idle_sig      = (cat_s == 8'hFF);
        cat_ok_sig    = sel_info_sig[3];
        smp_idx_sig   = sel_info_sig[2:0];
        seg_ok_sig    = seg_info_sig[5];
        smp_valid_sig = seg_info_sig[4];
        smp_bcd_sig   = seg_info_sig[3:0];
        err_cat_sig   = !idle_sig && !cat_ok_sig;
        err_seg_sig   = cat_ok_sig && !seg_ok_sig;
        accept_sig    = cat_ok_sig && seg_ok_sig;
    end

    // Per-digit stability filter next state and commit decision.
    always_comb begin
        for (int k = 0; k < NDIG; k++) begin
            cand_valid_nxt[k] = cand_valid_r[k];
            cand_bcd_nxt[k]   = cand_bcd_r[k];
            cnt_nxt[k]        = cnt_r[k];
            commit_sig[k]     = 1'b0;
            if (accept_sig && (smp_idx_sig == 3'(k))) begin
                if ((smp_valid_sig == cand_valid_r[k]) && (smp_bcd_sig == cand_bcd_r[k])) begin
                    cnt_nxt[k] = (cnt_r[k] == CNT_TOP) ? cnt_r[k] : cnt_r[k] + CNT_ONE;
                end else begin
                    cand_valid_nxt[k] = smp_valid_sig;
                    cand_bcd_nxt[k]   = smp_bcd_sig;
                    cnt_nxt[k]        = CNT_ONE;
                end
                // Only a changed result commits, so re-confirmation stays silent.
                commit_sig[k] = (cnt_nxt[k] == CNT_TOP) &&
                                ({cand_valid_nxt[k], cand_bcd_nxt[k]} !=
                                 {digit_valid[k], digit_bcd[4*k +: 4]});
            end else begin
                commit_sig[k] = 1'b0;
            end
        end
    end

    // Two-digit binary value from the committed registers.
    always_comb begin
        case (digit_valid[1:0])
            2'b11:   value_sig = ({3'b000, digit_bcd[7:4]} * 7'd10) + {3'b000, digit_bcd[3:0]};
            2'b01:   value_sig = {3'b000, digit_bcd[3:0]};
            default: value_sig = 7'd0;
        endcase
    end

    // Filter state, committed digits and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NDIG; k++) begin
                cand_valid_r[k] <= 1'b0;
                cand_bcd_r[k]   <= 4'd0;
                cnt_r[k]        <= '0;
            end
            digit_valid <= '0;
            digit_bcd   <= '0;
            value       <= 7'd0;
            update      <= 1'b0;
            err_cat     <= 1'b0;
            err_seg     <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            for (int k = 0; k < NDIG; k++) begin
                cand_valid_r[k] <= cand_valid_nxt[k];
                cand_bcd_r[k]   <= cand_bcd_nxt[k];
                cnt_r[k]        <= cnt_nxt[k];
                if (commit_sig[k]) begin
                    digit_valid[k]        <= cand_valid_nxt[k];
                    digit_bcd[4*k +: 4]   <= cand_bcd_nxt[k];
                end else begin
                    digit_valid[k]        <= digit_valid[k];
                    digit_bcd[4*k +: 4]   <= digit_bcd[4*k +: 4];
                end
            end
            value   <= value_sig;
            update  <= |commit_sig;
            err_cat <= err_cat_sig;
            err_seg <= err_seg_sig;
            if ((err_cat || err_seg) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end else begin
                err_count <= err_count;
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the team's multiplexed 7-segment display driver. It samples the scanned `cat`/`seg` bus, classifies the selected digit, and decodes each segment pattern back to BCD. A per-digit stability filter sits in front of a per-digit result register. The block is used for on-board loopback self-test of the display path and as a capture monitor in system benches. It also reports illegal patterns and illegal digit selects.

## Interface
- `NDIG`, 8: number of digit positions captured; must be 2..8.
- `STABLE`, 2: consecutive identical samples of a digit required before commit; must be ≥1.
- `clk`  in  1  system clock; the same clock drives the display driver.
- `reset`  in  1  asynchronous, active-high reset.
- `cat_in`  in  8  digit select, active-low one-hot; `8'hFF` means blank (no digit selected).
- `seg_in`  in  7  segments {a,b,c,d,e,f,g}, active-high.
- `digit_bcd`  out  4*NDIG  committed BCD per digit; digit k occupies [4k+3:4k].
- `digit_valid`  out  NDIG  committed digit holds a legal numeral; 0 means blank or never seen.
- `value`  out  7  digit1*10 + digit0 in binary, range 0..99.
- `update`  out  1  one-cycle pulse when any digit commits a changed result.
- `err_cat`  out  1  one-cycle pulse for an illegal select sample.
- `err_seg`  out  1  one-cycle pulse for an illegal segment sample.
- `err_count`  out  8  count of error samples; saturates at 255.

## Operation
- **Stage S:** `cat_in` and `seg_in` are registered every cycle into `cat_s` and `seg_s`. There is no other filtering on the inputs.
- **Select classification of `cat_s`:**
  - `8'hFF`: idle sample. Ignored, no error.
  - Exactly one zero, at bit k < NDIG: digit sample for index k.
  - Anything else, including a zero at bit ≥ NDIG or multiple zeros: `err_cat` pulses and the sample is dropped. In this case `seg_s` is not examined.
- **Segment decode of `seg_s` (digit samples only):**
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
  - 0000000 = blank; the candidate is {valid=0, bcd=0}.
  - Any other pattern: `err_seg` pulses and the sample is dropped.
- **Stability filter, per digit k:** each digit keeps a candidate {valid, bcd} and a match counter, 0..STABLE, saturating.
  - Accepted sample equal to the candidate: the counter increments.
  - Accepted sample different from the candidate: the candidate is loaded with the sample and the counter is set to 1.
  - The counter counts samples, not scans. A digit held selected for several cycles contributes several samples.
- **Commit:** occurs when the counter value after the update reaches STABLE and the candidate differs from the committed {digit_valid[k], digit_bcd[k]}.
  - The candidate is copied into the committed registers and `update` pulses.
  - Re-confirming a value that is already committed does not pulse `update`.
- **`value`:** equals digit_bcd[1]*10 + digit_bcd[0] when digit_valid[1:0] is 2'b11. Equals digit_bcd[0] when only digit_valid[0] is set. Equals 0 otherwise. Arithmetic is 7-bit unsigned with no overflow, since the maximum is 99.
- **`err_count`:** increments by 1 in each cycle where `err_cat` or `err_seg` is high. The two never assert in the same cycle.
- **Reset:** asynchronous and may occur mid-operation. It clears all state immediately: sample registers go to `cat_s`=FF and `seg_s`=0, all candidates, counters and committed registers go to 0, and every output goes to 0.

## Timing
- Inputs present during cycle N are captured at edge E(N).
- Classification and filtering use `cat_s`/`seg_s` during cycle N+1.
- `err_*` pulses, counter and candidate updates, and commit occur at edge E(N+1). `update`, `err_cat` and `err_seg` are high for exactly the one cycle following that edge.
- Commit of digit k takes effect at the edge E(N+1) of the STABLE-th consecutive identical sample of that digit.
- `value` is registered from the committed digits, so it changes one edge after `digit_bcd`/`digit_valid`.
- With STABLE=1:
  - Latency from input to `digit_bcd` is 2 edges.
  - Latency from input to `value` is 3 edges.
- The block has no back-pressure. Every cycle is processed.
- Samples of other digits and idle samples interleaved between samples of digit k do not reset digit k's counter.

## Test plan
- **Reset values:** Assert reset mid-stream -> all outputs 0 in the same cycle, asynchronously. After release with `cat_in`=FF, all outputs stay 0.
- **Basic decode:** STABLE=2. Alternate cat=FE/seg=0110000 and cat=FD/seg=1101101, one cycle each, for 4 cycles -> digit0=1 and digit1=2, each with `update` pulsing once. `value`=21 one edge later.
- **Filter reject:** STABLE=2. Drive digit0 with 1011011 for one sample, then 1111011 twice -> no commit of 5; 9 commits on the second 9-sample. Exactly one `update` pulse.
- **Blank:** Digit0 committed as 7, then digit0 driven with 0000000 for STABLE samples -> digit_valid[0]=0, `value`=0, `update` pulses once.
- **Illegal inputs:** Drive cat=FC, then cat=FE with seg=1000001 -> `err_cat`, then `err_seg`, one pulse each on consecutive cycles. `err_count`=2. Committed digits are unchanged.
- **Saturation and full range:** Drive 300 error samples -> `err_count` holds 255. Sweep 0..9 on both digits -> `value` covers 0..99 with the correct binary result.
